// File: rtl/wb_timer_array.sv
// NCH independent countdown timers on a Wishbone slave port, sharing one prescaler.
// Each channel is one-shot or periodic, with sticky done/overrun flags and a maskable IRQ.

module wb_timer_chan #(
  parameter int CNT_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             tick,
  input  logic             wr_ctrl,
  input  logic [3:0]       ctrl_d,
  input  logic             wr_load,
  input  logic [CNT_W-1:0] load_d,
  input  logic             clr_done,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] load,
  output logic             running,
  output logic             done,
  output logic             ovr,
  output logic             mask,
  output logic             periodic
);
  logic start, stop, expire;

  assign start  = wr_ctrl & ctrl_d[0];
  assign stop   = wr_ctrl & ctrl_d[3] & ~ctrl_d[0];
  // A start or stop landing on a tick edge suppresses that tick for this channel.
  assign expire = tick & running & ~start & ~stop & (cnt == CNT_W'(1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cnt      <= '0;
      load     <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      ovr      <= 1'b0;
      mask     <= 1'b1;
      periodic <= 1'b0;
    end else begin
      if (start) begin
        cnt     <= load;
        running <= |load;
      end else if (stop) begin
        running <= 1'b0;
      end else if (expire) begin
        // Reload reads the pre-edge LOAD, so a same-cycle LOAD write waits.
        cnt     <= periodic ? load : '0;
        running <= periodic & (|load);
      end else if (tick & running) begin
        cnt     <= cnt - 1'b1;
      end
      done <= expire | (done & ~clr_done);
      ovr  <= (expire & done) | (ovr & ~clr_ovr);
      if (wr_ctrl) begin
        mask     <= ctrl_d[1];
        periodic <= ctrl_d[2];
      end
      if (wr_load) load <= load_d;
    end
  end
endmodule

module wb_timer_array #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 50000000
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  input  logic           WB_CYC_I,
  input  logic           WB_STB_I,
  input  logic           WB_WE_I,
  input  logic [5:0]     WB_ADR_I,
  input  logic [31:0]    WB_DAT_I,
  input  logic [3:0]     WB_SEL_I,
  output logic           WB_ACK_O,
  output logic           WB_ERR_O,
  output logic           WB_RTY_O,
  output logic [31:0]    WB_DAT_O,
  output logic [NCH-1:0] IRQ_O,
  output logic           IRQ_ANY_O
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          acc, wr, rd, gw;
  logic          rd_vld;
  logic [5:0]    rd_adr;
  logic [31:0]   rdata;
  logic          unused;

  logic [NCH-1:0][CNT_W-1:0] cnt_v, load_v;
  logic [NCH-1:0]            run_v, done_v, ovr_v, mask_v, per_v;
  logic [NCH-1:0]            wr_ctrl, wr_load, clr_done, clr_ovr;

  assign unused = ^{WB_CYC_I, WB_SEL_I, WB_DAT_I};

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // One-cycle ACK; a held STB is only accepted while ACK is low.
  assign acc = WB_STB_I & ~WB_ACK_O;
  assign wr  = acc & WB_WE_I;
  assign rd  = acc & ~WB_WE_I;
  assign gw  = wr & (WB_ADR_I == 6'h3F);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      WB_ACK_O <= 1'b0;
      rd_vld   <= 1'b0;
      rd_adr   <= '0;
    end else begin
      WB_ACK_O <= acc;
      rd_vld   <= rd;
      if (rd) rd_adr <= WB_ADR_I;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_ctrl[i]  = wr & (WB_ADR_I == 6'(2 * i));
    assign wr_load[i]  = wr & (WB_ADR_I == 6'(2 * i + 1));
    assign clr_done[i] = (wr_ctrl[i] & WB_DAT_I[8])  | (gw & WB_DAT_I[i]);
    assign clr_ovr[i]  = (wr_ctrl[i] & WB_DAT_I[10]) | (gw & WB_DAT_I[8 + i]);

    wb_timer_chan #(.CNT_W(CNT_W)) u_ch (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .tick     (tick),
      .wr_ctrl  (wr_ctrl[i]),
      .ctrl_d   (WB_DAT_I[3:0]),
      .wr_load  (wr_load[i]),
      .load_d   (WB_DAT_I[CNT_W-1:0]),
      .clr_done (clr_done[i]),
      .clr_ovr  (clr_ovr[i]),
      .cnt      (cnt_v[i]),
      .load     (load_v[i]),
      .running  (run_v[i]),
      .done     (done_v[i]),
      .ovr      (ovr_v[i]),
      .mask     (mask_v[i]),
      .periodic (per_v[i])
    );
  end

  // Data is muxed from live state using the address captured at the request edge.
  always_comb begin
    rdata = '0;
    if (rd_adr == 6'h3F) begin
      rdata[NCH-1:0]   = done_v;
      rdata[8 +: NCH]  = ovr_v;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rd_adr == 6'(2 * i))
          rdata = {16'(cnt_v[i]), 5'b0, ovr_v[i], run_v[i], done_v[i],
                   5'b0, per_v[i], mask_v[i], 1'b0};
        if (rd_adr == 6'(2 * i + 1))
          rdata = 32'(load_v[i]);
      end
    end
  end

  assign WB_DAT_O  = rd_vld ? rdata : '0;
  assign WB_ERR_O  = 1'b0;
  assign WB_RTY_O  = 1'b0;
  assign IRQ_O     = done_v & ~mask_v;
  assign IRQ_ANY_O = |IRQ_O;
endmodule

// File: doc/wb_timer_array.md
# wb_timer_array

Parametrised multi-channel countdown timer on the Wishbone peripheral bus, generalising the two fixed 6-bit second timers into NCH independent channels of CNT_W bits. Each channel supports one-shot or periodic (auto-reload) mode, a sticky overrun flag, per-channel interrupt masking, and a shared programmable prescaler. It sits beside the existing peripheral slaves on the same bus segment and drives the CPU interrupt lines.

## Interface
- NCH, 4, number of channels (1..8)
- CNT_W, 16, counter/reload width (1..16)
- TICK_DIV, 50000000, CLK_I cycles per timer tick (≥2; 1 s at 50 MHz)
- CLK_I  in  1  system clock
- RST_I  in  1  reset, asynchronous, active-high
- WB_CYC_I  in  1  bus cycle (unused)
- WB_STB_I  in  1  strobe
- WB_WE_I  in  1  1 = write
- WB_ADR_I  in  6  word address
- WB_DAT_I  in  32  write data
- WB_SEL_I  in  4  byte select (ignored, full-word access only)
- WB_ACK_O  out  1  acknowledge
- WB_ERR_O  out  1  constant 0
- WB_RTY_O  out  1  constant 0
- WB_DAT_O  out  32  read data
- IRQ_O  out  NCH  per-channel interrupt, done & ~mask
- IRQ_ANY_O  out  1  OR of IRQ_O

## Operation
- Address map: CTRL(i) = 2i, LOAD(i) = 2i+1 for i < NCH; GSTAT = 6'h3F. All other addresses read 0; writes to them are ignored.
- LOAD(i): [CNT_W-1:0] reload value, read/write, reset 0.
- CTRL(i) write bits:
  - [0] start: cnt ← LOAD, running ← (LOAD ≠ 0).
  - [1] mask: 1 = masked; written on every CTRL write; reset 1.
  - [2] periodic: written on every CTRL write; reset 0.
  - [3] stop: running ← 0, cnt retained. Ignored when [0] is also set.
  - [8] write-1-clear done.
  - [10] write-1-clear ovr.
- CTRL(i) read: {cnt zero-extended to 16 bits in [31:16], 5'b0, ovr[10], running[9], done[8], 5'b0, periodic[2], mask[1], 1'b0}.
- GSTAT read: {16'b0, ovr[NCH-1:0] in [15:8], done[NCH-1:0] in [7:0]}, unused bits 0. GSTAT write: 1 in [7:0] clears done, 1 in [15:8] clears ovr.
- Prescaler: tick_cnt free-runs 0..TICK_DIV-1 from reset. tick = (tick_cnt == TICK_DIV-1). The prescaler is never reset by software.
- Channel on tick, while running and cnt > 1: cnt ← cnt-1.
- Expiry: tick while running and cnt == 1. Then cnt ← 0 and done ← 1.
  - If done was already 1, ovr ← 1.
  - One-shot: running ← 0.
  - Periodic: cnt ← LOAD, running ← (LOAD ≠ 0).
- Simultaneous events:
  - Start write and tick in the same cycle: start wins and no decrement occurs.
  - Expiry and done/ovr W1C in the same cycle: set wins.
  - LOAD write and periodic reload in the same cycle: reload uses the old LOAD value.
- Write to LOAD does not affect a running count until the next start or reload.
- Reset values: all cnt, done, ovr, running, periodic = 0; mask = 1; IRQ_O = 0; IRQ_ANY_O = 0; WB_ACK_O = 0; WB_DAT_O = 0.

## Timing
- WB_ACK_O rises the cycle after STB & ~ACK and is high for exactly one cycle. It then drops even if STB is held, so a held STB yields ACK every other cycle.
- Write access strobe = STB & WE & ~ACK. Registers update at that clock edge.
- Read: address decode is registered on STB & ~WE & ~ACK. WB_DAT_O is valid during the ACK cycle and returns 0 when no read is selected.
- done, ovr, cnt and IRQ_O update on the edge at which tick is high, with no further latency. IRQ_ANY_O is combinational from IRQ_O.
- Start to expiry: LOAD ticks. Wall time lies between (LOAD-1)·TICK_DIV+1 and LOAD·TICK_DIV cycles.
- Reset asserted mid-count returns the block to reset values immediately. The prescaler restarts at 0.

## Test plan
- Reset defaults, with TICK_DIV=4: CTRL(0) reads 0x00000002, GSTAT reads 0, IRQ_O = 0. Unmapped ADR 6'h20 reads 0.
- One-shot: LOAD(1)=3, CTRL(1)=0x1 (start, unmasked) → done and IRQ_O[1] rise after exactly 3 ticks and running=0. Write CTRL(1)=0x100 → IRQ_O[1] drops the next cycle.
- Periodic and overrun: LOAD(0)=2, CTRL(0)=0x5 → done every 2 ticks and cnt reloads to 2. Second expiry without a clear → ovr=1. GSTAT write 0x0101 → done=0, ovr=0.
- Mask and stop: LOAD(2)=5, CTRL(2)=0x3 → done=1 but IRQ_O[2]=0 on expiry. Restart, then CTRL(2)=0x8 after 2 ticks → cnt frozen at 3 over ≥3 ticks.
- Collisions:
  - Start write coincident with tick → cnt equals LOAD, not LOAD-1.
  - Expiry coincident with a done W1C → done stays 1.
  - Start with LOAD=0 → running=0 and no done.
- Bus: hold STB for 6 cycles → ACK pattern 0,1,0,1,0,1. Read data matches the register on each ACK. Assert RST_I mid-count → all outputs return to reset values asynchronously.
